// File: rtl/param_register_file_if.sv
// Bus between decode/writeback and the parametrised register file.
// master: decode/writeback side. It drives the write port, the read indices
//         and the issue request, and receives read data and busy flags.
// slave : the register file itself.
interface param_register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              reg_write;   // writeback enable
  logic [ADDR_W-1:0] rd;          // writeback register index
  logic [DATA_W-1:0] write_data;  // writeback data
  logic [ADDR_W-1:0] rs1;         // read port 1 index
  logic [ADDR_W-1:0] rs2;         // read port 2 index
  logic [DATA_W-1:0] read_data1;  // read port 1 data (combinational)
  logic [DATA_W-1:0] read_data2;  // read port 2 data (combinational)
  logic              issue_valid; // issued instruction will write issue_rd
  logic [ADDR_W-1:0] issue_rd;    // destination of the issued instruction
  logic              busy1;       // rs1 has a pending writeback
  logic              busy2;       // rs2 has a pending writeback
  logic              busy_any;    // OR of all busy bits

  modport master (
    output reg_write, rd, write_data, rs1, rs2, issue_valid, issue_rd,
    input  read_data1, read_data2, busy1, busy2, busy_any
  );

  modport slave (
    input  reg_write, rd, write_data, rs1, rs2, issue_valid, issue_rd,
    output read_data1, read_data2, busy1, busy2, busy_any
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised general-purpose register file with a per-register busy
// scoreboard for read-after-write hazard detection.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears registers and busy bits)
//   bus   : param_register_file_if.slave. It carries the write port
//           (reg_write/rd/write_data), two combinational read ports
//           (rs1/rs2 -> read_data1/2), issue (issue_valid/issue_rd) and
//           the busy outputs (busy1/busy2/busy_any).
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  param_register_file_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_wr_en;
  logic              w_issue_en;
  logic              w_fwd1;
  logic              w_fwd2;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  // Register 0 swallows writes and issues when hardwired to zero.
  assign w_wr_en    = bus.reg_write   && !((ZERO_REG != 0) && (bus.rd == '0));
  assign w_issue_en = bus.issue_valid && !((ZERO_REG != 0) && (bus.issue_rd == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[bus.rd] <= bus.write_data;
      end
      if (bus.reg_write) begin
        r_busy[bus.rd] <= 1'b0;
      end
      // Placed after the clear so a same-index issue wins (newer producer).
      if (w_issue_en) begin
        r_busy[bus.issue_rd] <= 1'b1;
      end
    end
  end

  // Busy masking uses the raw write match. A dropped write to r0 only
  // happens with ZERO_REG set, where busy[0] is never set anyway.
  assign w_fwd1 = (BYPASS != 0) && bus.reg_write && (bus.rd == bus.rs1);
  assign w_fwd2 = (BYPASS != 0) && bus.reg_write && (bus.rd == bus.rs2);

  always_comb begin
    w_rdata1 = r_regs[bus.rs1];
    if ((ZERO_REG != 0) && (bus.rs1 == '0)) begin
      w_rdata1 = '0;
    end else if (w_fwd1 && w_wr_en) begin
      w_rdata1 = bus.write_data;
    end
  end

  always_comb begin
    w_rdata2 = r_regs[bus.rs2];
    if ((ZERO_REG != 0) && (bus.rs2 == '0)) begin
      w_rdata2 = '0;
    end else if (w_fwd2 && w_wr_en) begin
      w_rdata2 = bus.write_data;
    end
  end

  assign bus.read_data1 = w_rdata1;
  assign bus.read_data2 = w_rdata2;
  assign bus.busy1      = r_busy[bus.rs1] & ~w_fwd1;
  assign bus.busy2      = r_busy[bus.rs2] & ~w_fwd2;
  assign bus.busy_any   = |r_busy;
endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Three small configs share one stimulus:
  // 0: bypass, no zero reg   1: no bypass   2: bypass + zero reg
  logic        s_rst_n, s_we, s_iv;
  logic [1:0]  s_rd, s_rs1, s_rs2, s_ird;
  logic [15:0] s_wd;

  param_register_file_if #(.DATA_W(16), .ADDR_W(2)) if_a ();
  param_register_file_if #(.DATA_W(16), .ADDR_W(2)) if_b ();
  param_register_file_if #(.DATA_W(16), .ADDR_W(2)) if_c ();

  assign if_a.reg_write = s_we;  assign if_b.reg_write = s_we;  assign if_c.reg_write = s_we;
  assign if_a.rd = s_rd;         assign if_b.rd = s_rd;         assign if_c.rd = s_rd;
  assign if_a.write_data = s_wd; assign if_b.write_data = s_wd; assign if_c.write_data = s_wd;
  assign if_a.rs1 = s_rs1;       assign if_b.rs1 = s_rs1;       assign if_c.rs1 = s_rs1;
  assign if_a.rs2 = s_rs2;       assign if_b.rs2 = s_rs2;       assign if_c.rs2 = s_rs2;
  assign if_a.issue_valid = s_iv; assign if_b.issue_valid = s_iv; assign if_c.issue_valid = s_iv;
  assign if_a.issue_rd = s_ird;  assign if_b.issue_rd = s_ird;  assign if_c.issue_rd = s_ird;

  param_register_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1))
    u_a (.clk(clk), .rst_n(s_rst_n), .bus(if_a));
  param_register_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0))
    u_b (.clk(clk), .rst_n(s_rst_n), .bus(if_b));
  param_register_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1))
    u_c (.clk(clk), .rst_n(s_rst_n), .bus(if_c));

  // Large config
  logic        l_rst_n, l_we, l_iv;
  logic [4:0]  l_rd, l_rs1, l_rs2, l_ird;
  logic [31:0] l_wd;

  param_register_file_if #(.DATA_W(32), .ADDR_W(5)) if_l ();
  assign if_l.reg_write = l_we;
  assign if_l.rd = l_rd;
  assign if_l.write_data = l_wd;
  assign if_l.rs1 = l_rs1;
  assign if_l.rs2 = l_rs2;
  assign if_l.issue_valid = l_iv;
  assign if_l.issue_rd = l_ird;

  param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1))
    u_l (.clk(clk), .rst_n(l_rst_n), .bus(if_l));

  // Reference state
  logic [15:0] m_reg  [3][4];
  bit          m_busy [3][4];
  bit          zr [3] = '{1'b0, 1'b0, 1'b1};
  bit          bp [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] lm_reg  [32];
  bit          lm_busy [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(int k, logic [1:0] rs);
    if (zr[k] && rs == 2'd0) return 16'h0;
    if (bp[k] && s_we && s_rd == rs && !(zr[k] && s_rd == 2'd0)) return s_wd;
    return m_reg[k][rs];
  endfunction

  function automatic bit exp_busy(int k, logic [1:0] rs);
    return m_busy[k][rs] && !(bp[k] && s_we && s_rd == rs);
  endfunction

  task automatic step(input logic rst, input logic we, input logic [1:0] rd,
                      input logic [15:0] wd, input logic [1:0] a1, input logic [1:0] a2,
                      input logic iv, input logic [1:0] ird);
    logic [15:0] o1, o2;
    logic        b1, b2, ba;
    bit          any;
    s_rst_n = rst; s_we = we; s_rd = rd; s_wd = wd;
    s_rs1 = a1; s_rs2 = a2; s_iv = iv; s_ird = ird;
    #4;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin o1 = if_a.read_data1; o2 = if_a.read_data2; b1 = if_a.busy1; b2 = if_a.busy2; ba = if_a.busy_any; end
        1: begin o1 = if_b.read_data1; o2 = if_b.read_data2; b1 = if_b.busy1; b2 = if_b.busy2; ba = if_b.busy_any; end
        default: begin o1 = if_c.read_data1; o2 = if_c.read_data2; b1 = if_c.busy1; b2 = if_c.busy2; ba = if_c.busy_any; end
      endcase
      any = 1'b0;
      for (int j = 0; j < 4; j++) any |= m_busy[k][j];
      check($sformatf("cfg%0d.rdata1", k), 32'(o1), 32'(exp_data(k, a1)));
      check($sformatf("cfg%0d.rdata2", k), 32'(o2), 32'(exp_data(k, a2)));
      check($sformatf("cfg%0d.busy1", k), 32'(b1), 32'(exp_busy(k, a1)));
      check($sformatf("cfg%0d.busy2", k), 32'(b2), 32'(exp_busy(k, a2)));
      check($sformatf("cfg%0d.busy_any", k), 32'(ba), 32'(any));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        for (int j = 0; j < 4; j++) begin m_reg[k][j] = '0; m_busy[k][j] = 1'b0; end
      end else begin
        if (we && !(zr[k] && rd == 2'd0)) m_reg[k][rd] = wd;
        if (we) m_busy[k][rd] = 1'b0;
        if (iv && !(zr[k] && ird == 2'd0)) m_busy[k][ird] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic lstep(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic [4:0] ird);
    bit any;
    l_rst_n = rst; l_we = we; l_rd = rd; l_wd = wd;
    l_rs1 = a1; l_rs2 = a2; l_iv = iv; l_ird = ird;
    #4;
    any = 1'b0;
    for (int j = 0; j < 32; j++) any |= lm_busy[j];
    check("big.rdata1", if_l.read_data1, (we && rd == a1) ? wd : lm_reg[a1]);
    check("big.rdata2", if_l.read_data2, (we && rd == a2) ? wd : lm_reg[a2]);
    check("big.busy1", 32'(if_l.busy1), 32'(lm_busy[a1] && !(we && rd == a1)));
    check("big.busy2", 32'(if_l.busy2), 32'(lm_busy[a2] && !(we && rd == a2)));
    check("big.busy_any", 32'(if_l.busy_any), 32'(any));
    @(posedge clk);
    if (!rst) begin
      for (int j = 0; j < 32; j++) begin lm_reg[j] = '0; lm_busy[j] = 1'b0; end
    end else begin
      if (we) begin lm_reg[rd] = wd; lm_busy[rd] = 1'b0; end
      if (iv) lm_busy[ird] = 1'b1;
    end
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) begin m_reg[k][j] = '0; m_busy[k][j] = 1'b0; end
    for (int j = 0; j < 32; j++) begin lm_reg[j] = '0; lm_busy[j] = 1'b0; end
    s_rst_n = 1'b0; s_we = 1'b0; s_rd = '0; s_wd = '0; s_rs1 = '0; s_rs2 = '0; s_iv = 1'b0; s_ird = '0;
    l_rst_n = 1'b0; l_we = 1'b0; l_rd = '0; l_wd = '0; l_rs1 = '0; l_rs2 = '0; l_iv = 1'b0; l_ird = '0;
    repeat (2) @(posedge clk);
    #1;
    l_rst_n = 1'b1;

    // Reset clears a written register
    step(1, 1, 2'd3, 16'hBEEF, 2'd3, 2'd3, 0, 2'd0);
    step(0, 1, 2'd2, 16'h1111, 2'd3, 2'd2, 1, 2'd1);
    step(1, 0, 2'd0, 16'h0000, 2'd3, 2'd1, 0, 2'd0);
    // Write/read with and without bypass
    step(1, 1, 2'd2, 16'h1234, 2'd2, 2'd0, 0, 2'd0);
    step(1, 0, 2'd0, 16'h0000, 2'd2, 2'd2, 0, 2'd0);
    // Back-to-back forwarded writes, both ports same index
    step(1, 1, 2'd1, 16'hA5A5, 2'd1, 2'd1, 0, 2'd0);
    step(1, 1, 2'd1, 16'h5A5A, 2'd1, 2'd1, 0, 2'd0);
    // Register 0: dropped write and ignored issue in the zero-reg config
    step(1, 1, 2'd0, 16'hFFFF, 2'd0, 2'd0, 0, 2'd0);
    step(1, 0, 2'd0, 16'h0000, 2'd0, 2'd0, 1, 2'd0);
    step(1, 1, 2'd0, 16'h0007, 2'd0, 2'd0, 0, 2'd0);
    // Scoreboard: issue, forwarded writeback, simultaneous set/clear
    step(1, 0, 2'd0, 16'h0000, 2'd1, 2'd3, 1, 2'd3);
    step(1, 0, 2'd0, 16'h0000, 2'd1, 2'd3, 0, 2'd0);
    step(1, 1, 2'd3, 16'h0042, 2'd1, 2'd3, 0, 2'd0);
    step(1, 0, 2'd0, 16'h0000, 2'd1, 2'd3, 0, 2'd0);
    step(1, 1, 2'd3, 16'h0099, 2'd3, 2'd3, 1, 2'd3);
    step(1, 0, 2'd0, 16'h0000, 2'd3, 2'd3, 0, 2'd0);
    step(1, 1, 2'd2, 16'h0055, 2'd3, 2'd2, 1, 2'd1);
    step(1, 0, 2'd0, 16'h0000, 2'd1, 2'd3, 0, 2'd0);

    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 31) != 0, 1'($urandom), 2'($urandom), 16'($urandom),
           2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
    s_we = 1'b0; s_iv = 1'b0;

    // Large config: fill, read mirrored pairs, hazards, mid-sequence reset
    for (int i = 0; i < 32; i++)
      lstep(1, 1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i), 0, 5'd0);
    for (int i = 0; i < 32; i++)
      lstep(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 0, 5'd0);
    for (int n = 0; n < 150; n++)
      lstep(1, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
            1'($urandom), 5'($urandom));
    lstep(1, 0, 5'd0, 32'h0, 5'd4, 5'd9, 1, 5'd9);
    lstep(0, 1, 5'd5, 32'hDEADBEEF, 5'd9, 5'd5, 1, 5'd6);
    for (int i = 0; i < 32; i++)
      lstep(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
